// File: rtl/sva_seq_impl_monitor.sv
// Multi-channel synthesizable checker for "a ##DELAY b |-> ##CONS_DELAY c".
// Reports pass/fail pulses, saturating counters, sticky errors and the first failure stamp.
module sva_seq_impl_monitor #(
    parameter int NUM_CH     = 4,
    parameter int DELAY      = 1,
    parameter int CONS_DELAY = 0,
    parameter int CNT_W      = 16,
    parameter int TS_W       = 32,
    localparam int CH_W      = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       a,
    input  logic [NUM_CH-1:0]       b,
    input  logic [NUM_CH-1:0]       c,
    output logic [NUM_CH-1:0]       pass,
    output logic [NUM_CH-1:0]       fail,
    output logic [NUM_CH*CNT_W-1:0] pass_cnt,
    output logic [NUM_CH*CNT_W-1:0] fail_cnt,
    output logic [NUM_CH-1:0]       err_sticky,
    output logic                    any_err,
    output logic [CH_W-1:0]         first_fail_ch,
    output logic [TS_W-1:0]         first_fail_cyc,
    output logic [TS_W-1:0]         cyc_cnt
);

    if (DELAY < 1) begin : g_bad_delay
        $fatal(1, "sva_seq_impl_monitor: DELAY must be >= 1");
    end
    if (CONS_DELAY < 0) begin : g_bad_cons
        $fatal(1, "sva_seq_impl_monitor: CONS_DELAY must be >= 0");
    end

    // Match pipeline is at least 1 bit wide; it is unused when the implication is overlapping.
    localparam int MW = (CONS_DELAY > 0) ? CONS_DELAY : 1;

    logic [DELAY-1:0]  start_pipe [NUM_CH];
    logic [MW-1:0]     match_pipe [NUM_CH];
    logic [NUM_CH-1:0] match_now;
    logic [NUM_CH-1:0] done_now;
    logic [NUM_CH-1:0] pass_now;
    logic [NUM_CH-1:0] fail_now;
    logic [CH_W-1:0]   first_idx;

    always_comb begin
        match_now = '0;
        done_now  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            match_now[i] = start_pipe[i][DELAY-1] & b[i];
            done_now[i]  = (CONS_DELAY == 0) ? match_now[i] : match_pipe[i][MW-1];
        end
        pass_now = done_now & c;
        fail_now = done_now & ~c;
    end

    // Descending scan so the lowest failing channel is the one left standing.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (fail_now[i]) first_idx = CH_W'(i);
        end
    end

    assign any_err = |err_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_pipe     <= '{default: '0};
            match_pipe     <= '{default: '0};
            pass           <= '0;
            fail           <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err_sticky     <= '0;
            first_fail_ch  <= '0;
            first_fail_cyc <= '0;
            cyc_cnt        <= '0;
        end else if (clr) begin
            start_pipe     <= '{default: '0};
            match_pipe     <= '{default: '0};
            pass           <= '0;
            fail           <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err_sticky     <= '0;
            first_fail_ch  <= '0;
            first_fail_cyc <= '0;
            cyc_cnt        <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + TS_W'(1);
            pass    <= pass_now;
            fail    <= fail_now;
            for (int i = 0; i < NUM_CH; i++) begin
                for (int k = DELAY - 1; k > 0; k--) begin
                    start_pipe[i][k] <= start_pipe[i][k-1];
                end
                start_pipe[i][0] <= en & a[i];
                if (CONS_DELAY > 0) begin
                    for (int k = MW - 1; k > 0; k--) begin
                        match_pipe[i][k] <= match_pipe[i][k-1];
                    end
                    match_pipe[i][0] <= match_now[i];
                end
                if (pass_now[i] && (pass_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    pass_cnt[i*CNT_W +: CNT_W] <= pass_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
                if (fail_now[i] && (fail_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    fail_cnt[i*CNT_W +: CNT_W] <= fail_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
                if (fail_now[i]) err_sticky[i] <= 1'b1;
            end
            if (!any_err && (|fail_now)) begin
                first_fail_ch  <= first_idx;
                first_fail_cyc <= cyc_cnt;
            end
        end
    end

endmodule

// File: tb/tb_sva_seq_impl_monitor.sv
// Directed bench: a table-driven run on an overlapping 2-bit-counter instance,
// then hand-written sequences on a non-overlapping instance for capture and clear.
module tb_sva_seq_impl_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Instance p: DELAY=1, CONS_DELAY=0, CNT_W=2, TS_W=8
    logic       pen = 0, pclr = 0;
    logic [3:0] pa = 0, pb = 0, pc = 0;
    logic [3:0] p_pass, p_fail, p_err;
    logic [7:0] p_pcnt, p_fcnt, p_ffcyc, p_cyc;
    logic       p_any;
    logic [1:0] p_ffch;

    // Instance q: DELAY=1, CONS_DELAY=1, CNT_W=16, TS_W=32
    logic        qen = 0, qclr = 0;
    logic [3:0]  qa = 0, qb = 0, qc = 0;
    logic [3:0]  q_pass, q_fail, q_err;
    logic [63:0] q_pcnt, q_fcnt;
    logic [31:0] q_ffcyc, q_cyc;
    logic        q_any;
    logic [1:0]  q_ffch;

    sva_seq_impl_monitor #(.NUM_CH(4), .DELAY(1), .CONS_DELAY(0), .CNT_W(2), .TS_W(8)) dut_p (
        .clk(clk), .rst(rst), .en(pen), .clr(pclr), .a(pa), .b(pb), .c(pc),
        .pass(p_pass), .fail(p_fail), .pass_cnt(p_pcnt), .fail_cnt(p_fcnt),
        .err_sticky(p_err), .any_err(p_any), .first_fail_ch(p_ffch),
        .first_fail_cyc(p_ffcyc), .cyc_cnt(p_cyc)
    );

    sva_seq_impl_monitor #(.NUM_CH(4), .DELAY(1), .CONS_DELAY(1), .CNT_W(16), .TS_W(32)) dut_q (
        .clk(clk), .rst(rst), .en(qen), .clr(qclr), .a(qa), .b(qb), .c(qc),
        .pass(q_pass), .fail(q_fail), .pass_cnt(q_pcnt), .fail_cnt(q_fcnt),
        .err_sticky(q_err), .any_err(q_any), .first_fail_ch(q_ffch),
        .first_fail_cyc(q_ffcyc), .cyc_cnt(q_cyc)
    );

    typedef struct {
        logic       en, clr;
        logic [3:0] a, b, c;
        logic [3:0] pass, fail, err;
        logic [7:0] pcnt, fcnt;
    } vec_t;

    vec_t vt [29];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pstep(input logic en_i, input logic clr_i, input logic [3:0] a_i, b_i, c_i);
        pen = en_i; pclr = clr_i; pa = a_i; pb = b_i; pc = c_i;
        @(posedge clk);
        #1;
    endtask

    task automatic qstep(input logic en_i, input logic clr_i, input logic [3:0] a_i, b_i, c_i);
        qen = en_i; qclr = clr_i; qa = a_i; qb = b_i; qc = c_i;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_cyc;

    initial begin
        //          en clr a     b     c     pass  fail  err   pcnt   fcnt
        vt[0]  = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00};
        vt[1]  = '{1, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00};
        vt[2]  = '{1, 0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 8'h01, 8'h00};
        vt[3]  = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h01, 8'h00};
        vt[4]  = '{1, 0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 8'h01, 8'h00};
        vt[5]  = '{1, 0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 8'h05, 8'h00};
        vt[6]  = '{1, 0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 8'h09, 8'h00};
        vt[7]  = '{1, 0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 8'h09, 8'h00};
        vt[8]  = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h09, 8'h00};
        vt[9]  = '{0, 0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h09, 8'h00};
        vt[10] = '{1, 0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 8'h09, 8'h00};
        vt[11] = '{1, 0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h09, 8'h00};
        vt[12] = '{0, 0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 8'h19, 8'h00};
        vt[13] = '{1, 0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h19, 8'h00};
        vt[14] = '{0, 0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 4'h8, 8'h19, 8'h40};
        vt[15] = '{1, 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00};
        vt[16] = '{1, 0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00};
        vt[17] = '{1, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 8'h01, 8'h00};
        vt[18] = '{1, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 8'h02, 8'h00};
        vt[19] = '{1, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 8'h03, 8'h00};
        vt[20] = '{1, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 8'h03, 8'h00};
        vt[21] = '{1, 0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 8'h03, 8'h00};
        vt[22] = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h03, 8'h00};
        vt[23] = '{1, 0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h03, 8'h00};
        vt[24] = '{0, 1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00};
        vt[25] = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00};
        vt[26] = '{1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00};
        vt[27] = '{0, 0, 4'h0, 4'hF, 4'h5, 4'h5, 4'hA, 4'hA, 8'h11, 8'h44};
        vt[28] = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 8'h11, 8'h44};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst p_pass", 64'(p_pass), 64'h0);
        chk("rst p_pcnt", 64'(p_pcnt), 64'h0);
        chk("rst p_cyc", 64'(p_cyc), 64'h0);
        chk("rst p_any", 64'(p_any), 64'h0);
        chk("rst q_fcnt", q_fcnt, 64'h0);
        chk("rst q_ffcyc", 64'(q_ffcyc), 64'h0);
        rst = 1'b0;
        exp_cyc = '0;

        for (int i = 0; i < 29; i++) begin
            pstep(vt[i].en, vt[i].clr, vt[i].a, vt[i].b, vt[i].c);
            exp_cyc = vt[i].clr ? 8'h00 : exp_cyc + 8'h01;
            chk($sformatf("v%0d pass", i), 64'(p_pass), 64'(vt[i].pass));
            chk($sformatf("v%0d fail", i), 64'(p_fail), 64'(vt[i].fail));
            chk($sformatf("v%0d err", i), 64'(p_err), 64'(vt[i].err));
            chk($sformatf("v%0d pass_cnt", i), 64'(p_pcnt), 64'(vt[i].pcnt));
            chk($sformatf("v%0d fail_cnt", i), 64'(p_fcnt), 64'(vt[i].fcnt));
            chk($sformatf("v%0d cyc", i), 64'(p_cyc), 64'(exp_cyc));
        end
        // Simultaneous first failures on ch1 and ch3 at the vt[27] edge (pre-increment cyc 2)
        chk("p any_err", 64'(p_any), 64'h1);
        chk("p first_fail_ch", 64'(p_ffch), 64'h1);
        chk("p first_fail_cyc", 64'(p_ffcyc), 64'h2);

        // cyc_cnt wraps at 2^8
        for (int i = 0; i < 260; i++) begin
            pstep(0, 0, 4'h0, 4'h0, 4'h0);
            exp_cyc = exp_cyc + 8'h01;
        end
        chk("p cyc wrap", 64'(p_cyc), 64'(exp_cyc));

        // Async reset between edges with an attempt in flight on ch0
        pstep(1, 0, 4'h1, 4'h0, 4'h0);
        #2 rst = 1'b1;
        #1;
        chk("arst p_pcnt", 64'(p_pcnt), 64'h0);
        chk("arst p_err", 64'(p_err), 64'h0);
        chk("arst p_cyc", 64'(p_cyc), 64'h0);
        chk("arst p_ffcyc", 64'(p_ffcyc), 64'h0);
        #2 rst = 1'b0;
        pstep(0, 0, 4'h0, 4'h1, 4'h1);  // edge 1 after release
        chk("arst no pass", 64'(p_pass), 64'h0);
        chk("arst p_cyc1", 64'(p_cyc), 64'h1);
        pen = 0; pa = 0; pb = 0; pc = 0;

        // Instance q: edge k after release has pre-increment cyc k-1
        qstep(0, 0, 4'h0, 4'h0, 4'h0);  // edge 2
        qstep(0, 0, 4'h0, 4'h0, 4'h0);  // edge 3
        qstep(0, 0, 4'h0, 4'h0, 4'h0);  // edge 4
        chk("q cyc4", 64'(q_cyc), 64'd4);
        qstep(1, 0, 4'h5, 4'h0, 4'h0);  // edge 5: start ch0, ch2
        qstep(0, 0, 4'h0, 4'h5, 4'h0);  // edge 6: match
        chk("q e6 pass", 64'(q_pass), 64'h0);
        chk("q e6 fail", 64'(q_fail), 64'h0);
        qstep(0, 0, 4'h0, 4'h0, 4'h1);  // edge 7: c sampled
        chk("q e7 pass", 64'(q_pass), 64'h1);
        chk("q e7 fail", 64'(q_fail), 64'h4);
        chk("q e7 err", 64'(q_err), 64'h4);
        chk("q e7 any", 64'(q_any), 64'h1);
        chk("q e7 ffch", 64'(q_ffch), 64'h2);
        chk("q e7 ffcyc", 64'(q_ffcyc), 64'd6);
        chk("q e7 cyc", 64'(q_cyc), 64'd7);
        chk("q e7 pcnt", q_pcnt, 64'h0000_0000_0000_0001);
        chk("q e7 fcnt", q_fcnt, 64'h0000_0001_0000_0000);
        qstep(1, 0, 4'h2, 4'h0, 4'h0);  // edge 8: start ch1
        chk("q e8 fail", 64'(q_fail), 64'h0);
        qstep(0, 0, 4'h0, 4'h2, 4'h0);  // edge 9
        qstep(0, 0, 4'h0, 4'h0, 4'h0);  // edge 10: ch1 fails
        chk("q e10 fail", 64'(q_fail), 64'h2);
        chk("q e10 err", 64'(q_err), 64'h6);
        chk("q e10 ffch", 64'(q_ffch), 64'h2);
        chk("q e10 ffcyc", 64'(q_ffcyc), 64'd6);
        chk("q e10 fcnt", q_fcnt, 64'h0000_0001_0001_0000);
        qstep(1, 0, 4'h8, 4'h0, 4'h0);  // edge 11: start ch3
        qstep(0, 1, 4'h0, 4'h8, 4'h0);  // edge 12: clr on the b edge
        chk("q clr cyc", 64'(q_cyc), 64'h0);
        chk("q clr err", 64'(q_err), 64'h0);
        chk("q clr any", 64'(q_any), 64'h0);
        chk("q clr fcnt", q_fcnt, 64'h0);
        chk("q clr pcnt", q_pcnt, 64'h0);
        chk("q clr ffcyc", 64'(q_ffcyc), 64'h0);
        qstep(0, 0, 4'h0, 4'h0, 4'h0);  // edge 13: flushed attempt must stay silent
        chk("q e13 fail", 64'(q_fail), 64'h0);
        chk("q e13 cyc", 64'(q_cyc), 64'h1);
        qstep(1, 0, 4'hA, 4'h0, 4'h0);  // edge 14
        qstep(0, 0, 4'h0, 4'hA, 4'h0);  // edge 15
        qstep(0, 0, 4'h0, 4'h0, 4'h0);  // edge 16: ch1 and ch3 fail together
        chk("q e16 fail", 64'(q_fail), 64'hA);
        chk("q e16 ffch", 64'(q_ffch), 64'h1);
        chk("q e16 ffcyc", 64'(q_ffcyc), 64'd3);
        chk("q e16 err", 64'(q_err), 64'hA);
        qstep(0, 0, 4'h0, 4'h0, 4'h0);
        chk("q e17 fail", 64'(q_fail), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
